// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MIPS memory responder: FSM states,
// error-source codes and the per-port window/alignment decode.
package mips_mem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam logic [WORD_W-1:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

    localparam logic ERR_SRC_INSTR = 1'b0;
    localparam logic ERR_SRC_DATA  = 1'b1;

    typedef struct packed {
        logic        ok;
        logic [29:0] idx;
    } decode_t;

    // Addresses below base wrap to large offsets and miss the window.
    function automatic decode_t decode(input logic [WORD_W-1:0] addr,
                                       input logic [WORD_W-1:0] base,
                                       input int unsigned depth_log2);
        logic [WORD_W-1:0] off;
        decode_t d;
        off   = addr - base;
        d.ok  = ((off >> (depth_log2 + 2)) == '0) && (addr[1:0] == 2'b00);
        d.idx = off[WORD_W-1:2];
        return d;
    endfunction

endpackage

// File: rtl/mips_mem_array.sv
// Word array with one write port and two registered, read-first read ports.
// Storage is intentionally not reset.
module mips_mem_array
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 19
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WORD_W-1:0]     wdata,
    input  logic                  re_a,
    input  logic [DEPTH_LOG2-1:0] raddr_a,
    output logic [WORD_W-1:0]     rdata_a,
    input  logic                  re_b,
    input  logic [DEPTH_LOG2-1:0] raddr_b,
    output logic [WORD_W-1:0]     rdata_b
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re_a) begin
            rdata_a <= mem[raddr_a];
        end
        if (re_b) begin
            rdata_b <= mem[raddr_b];
        end
    end

endmodule

// File: rtl/mips_mem_responder.sv
// Memory responder for the multi-cycle MIPS core: post-reset clear sweep,
// window decode, registered reads, synchronous writes and sticky error log.
module mips_mem_responder
    import mips_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
    parameter int unsigned DEPTH_LOG2 = 19,
    parameter bit          INIT_CLEAR = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr_rdata,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic        data_rd_wr,
    output logic [31:0] data_rdata,
    output logic        ready,
    output logic        err,
    output logic        err_src,
    output logic [31:0] err_addr,
    input  logic        err_clr
);

    localparam state_t                RESET_STATE = INIT_CLEAR ? CLEAR : RUN;
    localparam logic [DEPTH_LOG2-1:0] LAST_IDX    = '1;

    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic                  ready_q, ready_d;
    logic                  err_q, err_d;
    logic                  err_src_q, err_src_d;
    logic [31:0]           err_addr_q, err_addr_d;
    logic                  instr_vld_q, instr_vld_d;
    logic                  data_vld_q, data_vld_d;

    logic                  mem_we, re_a, re_b;
    logic [DEPTH_LOG2-1:0] mem_waddr;
    logic [WORD_W-1:0]     mem_wdata, arr_rdata_a, arr_rdata_b;

    decode_t               instr_dec, data_dec;
    logic [DEPTH_LOG2-1:0] instr_idx, data_idx;
    logic                  unused_idx_bits;

    assign instr_dec       = decode(instr_addr, BASE_ADDR, DEPTH_LOG2);
    assign data_dec        = decode(data_addr, BASE_ADDR, DEPTH_LOG2);
    assign instr_idx       = instr_dec.idx[DEPTH_LOG2-1:0];
    assign data_idx        = data_dec.idx[DEPTH_LOG2-1:0];
    assign unused_idx_bits = ^{instr_dec.idx[29:DEPTH_LOG2], data_dec.idx[29:DEPTH_LOG2]};

    mips_mem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
        .clk     (clk),
        .we      (mem_we),
        .waddr   (mem_waddr),
        .wdata   (mem_wdata),
        .re_a    (re_a),
        .raddr_a (instr_idx),
        .rdata_a (arr_rdata_a),
        .re_b    (re_b),
        .raddr_b (data_idx),
        .rdata_b (arr_rdata_b)
    );

    // Valid flags gate the unreset array read registers so outputs are 0 from reset.
    assign instr_rdata = instr_vld_q ? arr_rdata_a : '0;
    assign data_rdata  = data_vld_q  ? arr_rdata_b : '0;
    assign ready       = ready_q;
    assign err         = err_q;
    assign err_src     = err_src_q;
    assign err_addr    = err_addr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RESET_STATE;
            idx_q       <= '0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            err_src_q   <= 1'b0;
            err_addr_q  <= '0;
            instr_vld_q <= 1'b0;
            data_vld_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
            err_src_q   <= err_src_d;
            err_addr_q  <= err_addr_d;
            instr_vld_q <= instr_vld_d;
            data_vld_q  <= data_vld_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ready_d     = ready_q;
        err_d       = err_q;
        err_src_d   = err_src_q;
        err_addr_d  = err_addr_q;
        instr_vld_d = instr_vld_q;
        data_vld_d  = data_vld_q;
        mem_we      = 1'b0;
        mem_waddr   = data_idx;
        mem_wdata   = data_wdata;
        re_a        = 1'b0;
        re_b        = 1'b0;

        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = idx_q;
                mem_wdata = '0;
                idx_d     = idx_q + DEPTH_LOG2'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                end
            end
            RUN: begin
                ready_d     = 1'b1;
                re_a        = instr_dec.ok;
                instr_vld_d = instr_dec.ok;
                if (data_rd_wr) begin
                    re_b       = data_dec.ok;
                    data_vld_d = data_dec.ok;
                end else begin
                    mem_we = data_dec.ok;
                end
                // A fault in the same cycle as err_clr re-arms capture with the new fault.
                if (!instr_dec.ok || !data_dec.ok) begin
                    err_d = 1'b1;
                    if (!err_q || err_clr) begin
                        err_src_d  = instr_dec.ok ? ERR_SRC_DATA : ERR_SRC_INSTR;
                        err_addr_d = instr_dec.ok ? data_addr : instr_addr;
                    end
                end else if (err_clr) begin
                    err_d      = 1'b0;
                    err_src_d  = 1'b0;
                    err_addr_d = '0;
                end
            end
            default: ;
        endcase
    end

endmodule
